// File: rtl/execute_pkg.sv
// Shared execute-stage definitions: ALU op encodings, EFLAGS bit positions,
// reserved-bit handling and the per-op flag merge used by the EFLAGS unit.
package execute_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpOr  = 3'd1,
    OpNot = 3'd2,
    OpDaa = 3'd3,
    OpAnd = 3'd4,
    OpCld = 3'd5,
    OpSub = 3'd6,
    OpStd = 3'd7
  } alu_op_e;

  // Condition codes come in pairs; the low tttn bit negates the pair's base test.
  typedef enum logic [2:0] {
    CcPairO  = 3'd0,
    CcPairB  = 3'd1,
    CcPairE  = 3'd2,
    CcPairBe = 3'd3,
    CcPairS  = 3'd4,
    CcPairP  = 3'd5,
    CcPairL  = 3'd6,
    CcPairLe = 3'd7
  } cc_pair_e;

  typedef enum logic [0:0] {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } state_e;

  localparam int unsigned FlagCf = 0;
  localparam int unsigned FlagPf = 2;
  localparam int unsigned FlagAf = 4;
  localparam int unsigned FlagZf = 6;
  localparam int unsigned FlagSf = 7;
  localparam int unsigned FlagDf = 10;
  localparam int unsigned FlagOf = 11;

  localparam logic [31:0] BitCf = 32'(1) << FlagCf;
  localparam logic [31:0] BitPf = 32'(1) << FlagPf;
  localparam logic [31:0] BitAf = 32'(1) << FlagAf;
  localparam logic [31:0] BitZf = 32'(1) << FlagZf;
  localparam logic [31:0] BitSf = 32'(1) << FlagSf;
  localparam logic [31:0] BitDf = 32'(1) << FlagDf;
  localparam logic [31:0] BitOf = 32'(1) << FlagOf;

  localparam logic [31:0] MaskArith = BitOf | BitSf | BitZf | BitAf | BitPf | BitCf;
  localparam logic [31:0] MaskLogic = BitOf | BitSf | BitZf | BitPf | BitCf;
  localparam logic [31:0] MaskDaa   = BitSf | BitZf | BitAf | BitPf | BitCf;

  // Bit 1 always reads as one; bits 3, 5, 15 and 22-31 always read as zero.
  localparam logic [31:0] EflagsRsvdOne  = 32'h0000_0002;
  localparam logic [31:0] EflagsRsvdZero = 32'hFFC0_8028;
  localparam logic [31:0] EflagsReset    = 32'h0000_0002;

  function automatic logic [31:0] op_update_mask(alu_op_e op);
    logic [31:0] mask;
    case (op)
      OpAdd, OpSub: mask = MaskArith;
      OpOr, OpAnd:  mask = MaskLogic;
      OpDaa:        mask = MaskDaa;
      OpCld, OpStd: mask = BitDf;
      default:      mask = '0;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] eflags_merge(logic [31:0] arch, logic [31:0] flags,
                                               alu_op_e op);
    logic [31:0] mask;
    logic [31:0] src;
    logic [31:0] res;
    mask = op_update_mask(op);
    src  = flags;
    // CLD/STD write a fixed direction flag regardless of the ALU flags.
    if (op == OpCld) begin
      src = '0;
    end else if (op == OpStd) begin
      src = BitDf;
    end
    res = (arch & ~mask) | (src & mask);
    return (res | EflagsRsvdOne) & ~EflagsRsvdZero;
  endfunction

endpackage

// File: rtl/cc_eval.sv
// Combinational x86 condition-code (tttn) evaluator over an EFLAGS value.
module cc_eval
  import execute_pkg::*;
(
  input  logic [31:0] flags_i,
  input  logic [3:0]  cc_i,
  output logic        taken_o
);

  logic of, sf, zf, pf, cf;
  logic base;
  logic unused_flags;

  assign of = flags_i[FlagOf];
  assign sf = flags_i[FlagSf];
  assign zf = flags_i[FlagZf];
  assign pf = flags_i[FlagPf];
  assign cf = flags_i[FlagCf];

  assign unused_flags = ^{flags_i[31:12], flags_i[10:8], flags_i[5:3], flags_i[1]};

  always_comb begin
    base = 1'b0;
    unique case (cc_pair_e'(cc_i[3:1]))
      CcPairO:  base = of;
      CcPairB:  base = cf;
      CcPairE:  base = zf;
      CcPairBe: base = cf | zf;
      CcPairS:  base = sf;
      CcPairP:  base = pf;
      CcPairL:  base = sf ^ of;
      CcPairLe: base = zf | (sf ^ of);
      default:  base = 1'b0;
    endcase
    taken_o = base ^ cc_i[0];
  end

endmodule

// File: rtl/eflags_unit.sv
// EFLAGS merge unit: folds ALU flags into the architectural EFLAGS per op and
// presents the merged value plus an optional condition result in a one-entry output buffer.
module eflags_unit
  import execute_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_flags,
  input  logic [3:0]  in_cc,
  input  logic        in_cc_req,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_eflags,
  output logic        out_cc_taken,
  output logic [31:0] arch_eflags
);

  state_e      state_q, state_d;
  logic [31:0] arch_q, arch_d;
  logic [31:0] out_eflags_q, out_eflags_d;
  logic        cc_taken_q, cc_taken_d;
  logic [31:0] merged;
  logic        cc_taken_raw;
  logic        accept;

  assign out_valid    = (state_q == StFull);
  assign in_ready     = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign out_eflags   = out_eflags_q;
  assign out_cc_taken = cc_taken_q;
  assign arch_eflags  = arch_q;

  assign merged = eflags_merge(arch_q, in_flags, alu_op_e'(in_op));

  // Condition is judged on the freshly merged flags, not the old register.
  cc_eval u_cc_eval (
    .flags_i (merged),
    .cc_i    (in_cc),
    .taken_o (cc_taken_raw)
  );

  always_comb begin
    state_d      = state_q;
    arch_d       = arch_q;
    out_eflags_d = out_eflags_q;
    cc_taken_d   = cc_taken_q;
    if (accept) begin
      state_d      = StFull;
      arch_d       = merged;
      out_eflags_d = merged;
      cc_taken_d   = in_cc_req && cc_taken_raw;
    end else if (flush) begin
      state_d = StEmpty;
    end else if (state_q == StFull && out_ready) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StEmpty;
      arch_q       <= EflagsReset;
      out_eflags_q <= EflagsReset;
      cc_taken_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      arch_q       <= arch_d;
      out_eflags_q <= out_eflags_d;
      cc_taken_q   <= cc_taken_d;
    end
  end

endmodule

// File: tb/tb_eflags_unit.sv
// Bench for eflags_unit: directed scenarios followed by randomized traffic against a flag-level model.
module tb_eflags_unit;

  logic        CLK;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_flags;
  logic [3:0]  in_cc;
  logic        in_cc_req;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_eflags;
  logic        out_cc_taken;
  logic [31:0] arch_eflags;

  eflags_unit dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_flags     (in_flags),
    .in_cc        (in_cc),
    .in_cc_req    (in_cc_req),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_eflags   (out_eflags),
    .out_cc_taken (out_cc_taken),
    .arch_eflags  (arch_eflags)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  logic [31:0] m_arch;
  logic [31:0] m_out;
  logic        m_valid;
  logic        m_cc;

  // Flag-by-flag reference merge: copy the listed flags, then fix reserved bits.
  function automatic logic [31:0] ref_merge(input logic [31:0] arch, input logic [2:0] op,
                                            input logic [31:0] fl);
    int unsigned upd[$];
    logic [31:0] r;
    r = arch;
    case (op)
      3'd0, 3'd6: upd = '{11, 7, 6, 4, 2, 0};
      3'd1, 3'd4: upd = '{11, 7, 6, 2, 0};
      3'd3:       upd = '{7, 6, 4, 2, 0};
      default:    upd.delete();
    endcase
    foreach (upd[i]) r[upd[i]] = fl[upd[i]];
    if (op == 3'd5) r[10] = 1'b0;
    if (op == 3'd7) r[10] = 1'b1;
    r[1]  = 1'b1;
    r[3]  = 1'b0;
    r[5]  = 1'b0;
    r[15] = 1'b0;
    for (int b = 22; b < 32; b++) r[b] = 1'b0;
    return r;
  endfunction

  function automatic logic ref_cc(input logic [31:0] f, input logic [3:0] cc);
    logic t;
    case (cc[3:1])
      3'd0:    t = f[11];
      3'd1:    t = f[0];
      3'd2:    t = f[6];
      3'd3:    t = f[0] || f[6];
      3'd4:    t = f[7];
      3'd5:    t = f[2];
      3'd6:    t = f[7] != f[11];
      default: t = f[6] || (f[7] != f[11]);
    endcase
    return cc[0] ? !t : t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check in_ready, clock, advance the model, check outputs.
  task automatic cycle(input logic rst, input logic v, input logic [2:0] op,
                       input logic [31:0] fl, input logic [3:0] cc, input logic ccr,
                       input logic fsh, input logic ordy);
    logic        m_ready;
    logic        acc;
    logic [31:0] mg;
    RST       = rst;
    in_valid  = v;
    in_op     = op;
    in_flags  = fl;
    in_cc     = cc;
    in_cc_req = ccr;
    flush     = fsh;
    out_ready = ordy;
    #1;
    m_ready = !m_valid || ordy;
    acc     = v && m_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
    @(posedge CLK);
    #1;
    if (rst) begin
      m_arch  = 32'h0000_0002;
      m_out   = 32'h0000_0002;
      m_valid = 1'b0;
      m_cc    = 1'b0;
    end else if (acc) begin
      mg      = ref_merge(m_arch, op, fl);
      m_arch  = mg;
      m_out   = mg;
      m_valid = 1'b1;
      m_cc    = ccr && ref_cc(mg, cc);
    end else if (fsh) begin
      m_valid = 1'b0;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    chk("arch_eflags", arch_eflags, m_arch);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid || rst) begin
      chk("out_eflags", out_eflags, m_out);
      chk("out_cc_taken", {31'd0, out_cc_taken}, {31'd0, m_cc});
    end
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_flags = '0; in_cc = '0;
    in_cc_req = 1'b0; flush = 1'b0; out_ready = 1'b0;
    m_arch = 32'h0000_0002; m_out = 32'h0000_0002; m_valid = 1'b0; m_cc = 1'b0;
    @(posedge CLK);
    #1;

    // Reset state
    cycle(1, 0, 3'd0, '0, 4'd0, 0, 0, 0);
    cycle(1, 0, 3'd0, '0, 4'd0, 0, 0, 0);
    chk("rst_arch", arch_eflags, 32'h0000_0002);
    chk("rst_out", out_eflags, 32'h0000_0002);

    // ADD with ZF,CF
    cycle(0, 1, 3'd0, 32'h0000_0041, 4'd0, 0, 0, 1);
    chk("add_out", out_eflags, 32'h0000_0043);
    chk("add_arch", arch_eflags, 32'h0000_0043);

    // Build arch 0x893 then OR keeps AF
    cycle(0, 1, 3'd0, 32'h0000_0891, 4'd0, 0, 0, 1);
    chk("arch_893", arch_eflags, 32'h0000_0893);
    cycle(0, 1, 3'd1, 32'h0000_0044, 4'd0, 0, 0, 1);
    chk("or_out", out_eflags, 32'h0000_0056);

    // STD then CLD back-to-back
    cycle(0, 1, 3'd7, 32'hFFFF_FFFF, 4'd0, 0, 0, 1);
    chk("std_arch", arch_eflags, 32'h0000_0456);
    cycle(0, 1, 3'd5, 32'hFFFF_FFFF, 4'd0, 0, 0, 1);
    chk("cld_arch", arch_eflags, 32'h0000_0056);

    // SUB OF,SF with L then NE
    cycle(0, 1, 3'd6, 32'h0000_0880, 4'd12, 1, 0, 1);
    chk("sub_l", {31'd0, out_cc_taken}, 32'd0);
    chk("sub_out", out_eflags, 32'h0000_0882);
    cycle(0, 1, 3'd6, 32'h0000_0880, 4'd5, 1, 0, 1);
    chk("sub_ne", {31'd0, out_cc_taken}, 32'd1);

    // Backpressure: hold for three cycles, then flush
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 3'd0, $urandom, 4'd4, 1, 0, 0);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out", out_eflags, 32'h0000_0882);
    end
    cycle(0, 0, 3'd0, '0, 4'd0, 0, 1, 0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_arch", arch_eflags, 32'h0000_0882);

    // Flush with simultaneous accept: accept wins
    cycle(0, 1, 3'd4, 32'h0000_00C4, 4'd4, 1, 1, 1);
    chk("flush_acc_valid", {31'd0, out_valid}, 32'd1);

    // Reset while FULL with in_valid high
    cycle(0, 1, 3'd0, 32'h0000_08D5, 4'd0, 0, 0, 0);
    cycle(1, 1, 3'd0, 32'h0000_0001, 4'd0, 1, 0, 0);
    chk("rst_full_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_full_arch", arch_eflags, 32'h0000_0002);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
